// File: rtl/arb_pkg.sv
// Shared types and default widths for the I/D-cache pmem arbiter.
// The cache and memory model use the same width defaults.
package arb_pkg;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the I-cache and D-cache requests.
// RR_EN=1 alternates on contention; RR_EN=0 always favours the D-cache.
module arb_pick
   import arb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic    i_req,
   input  logic    d_req,
   input  req_id_e last_grant,
   output logic    any_req,
   output req_id_e winner
);

   // A lone requester always wins; contention is settled by the pick rule.
   always_comb begin
      any_req = i_req | d_req;
      winner  = REQ_I;
      if (d_req && !i_req) begin
         winner = REQ_D;
      end else if (d_req && i_req) begin
         if (RR_EN) begin
            winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
         end else begin
            winner = REQ_D;
         end
      end
   end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one pmem cacheline port between the I-cache and the D-cache.
// One whole-line transaction at a time; the granted command is latched and held
// until pmem_resp, then a mandatory IDLE cycle lets the served cache drop its request.
module cacheline_arbiter #(
   parameter int ADDR_W = arb_pkg::ADDR_W,
   parameter int LINE_W = arb_pkg::LINE_W,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   import arb_pkg::*;

   arb_state_e        state_reg;
   req_id_e           last_grant_reg;
   logic              pmem_read_reg;
   logic              pmem_write_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [LINE_W-1:0] wdata_reg;

   logic              d_req;
   logic              any_req;
   req_id_e           winner;

   assign d_req = d_read | d_write;

   arb_pick #(
      .RR_EN(RR_EN)
   ) u_pick (
      .i_req      (i_read),
      .d_req      (d_req),
      .last_grant (last_grant_reg),
      .any_req    (any_req),
      .winner     (winner)
   );

   // Grant FSM: latch the winner's command in IDLE, hold it until pmem_resp.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= REQ_I;
         pmem_read_reg  <= 1'b0;
         pmem_write_reg <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  last_grant_reg <= winner;
                  if (winner == REQ_D) begin
                     // A write-back wins over a simultaneous (illegal) read.
                     state_reg      <= GNT_D;
                     pmem_write_reg <= d_write;
                     pmem_read_reg  <= ~d_write;
                     addr_reg       <= d_address;
                     wdata_reg      <= d_wdata;
                  end else begin
                     state_reg      <= GNT_I;
                     pmem_write_reg <= 1'b0;
                     pmem_read_reg  <= 1'b1;
                     addr_reg       <= i_address;
                     wdata_reg      <= '0;
                  end
               end
            end
            GNT_I, GNT_D: begin
               if (pmem_resp) begin
                  state_reg      <= IDLE;
                  pmem_read_reg  <= 1'b0;
                  pmem_write_reg <= 1'b0;
               end
            end
            default: begin
               state_reg      <= IDLE;
               pmem_read_reg  <= 1'b0;
               pmem_write_reg <= 1'b0;
            end
         endcase
      end
   end

   assign pmem_read    = pmem_read_reg;
   assign pmem_write   = pmem_write_reg;
   assign pmem_address = addr_reg;
   assign pmem_wdata   = wdata_reg;

   // Response steering is combinational so the cache sees resp in the pmem_resp cycle.
   assign i_resp  = (state_reg == GNT_I) && pmem_resp;
   assign d_resp  = (state_reg == GNT_D) && pmem_resp;
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

   // Simulation checks for protocol misuse by the caches or the memory.
   a_no_rw_both: assert property (@(posedge clk) disable iff (rst)
      !(d_read && d_write));
   a_no_idle_resp: assert property (@(posedge clk) disable iff (rst)
      (state_reg == IDLE) |-> !pmem_resp);

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: two instances (u0 fixed priority, u1 round-robin),
// each with its own 10-cycle memory model; a scoreboard of expected read data.
module tb_cacheline_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         sel = 1'b1;
   logic         i_read = 1'b0;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [31:0]  i_address = '0;
   logic [31:0]  d_address = '0;
   logic [255:0] d_wdata = '0;
   int           cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 2; gi++) begin : g_u
      logic [255:0] i_rdata, d_rdata, pmem_wdata, pmem_rdata;
      logic         i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
      logic [31:0]  pmem_address;
      logic [255:0] mem [logic [31:0]];
      int           cnt;
      logic         busy;

      cacheline_arbiter #(
         .ADDR_W(32), .LINE_W(256), .RR_EN(1'(gi))
      ) dut (
         .clk          (clk),
         .rst          (rst),
         .i_read       (i_read && (sel == 1'(gi))),
         .i_address    (i_address),
         .i_rdata      (i_rdata),
         .i_resp       (i_resp),
         .d_read       (d_read && (sel == 1'(gi))),
         .d_write      (d_write && (sel == 1'(gi))),
         .d_address    (d_address),
         .d_wdata      (d_wdata),
         .d_rdata      (d_rdata),
         .d_resp       (d_resp),
         .pmem_read    (pmem_read),
         .pmem_write   (pmem_write),
         .pmem_address (pmem_address),
         .pmem_wdata   (pmem_wdata),
         .pmem_rdata   (pmem_rdata),
         .pmem_resp    (pmem_resp)
      );

      initial begin
         mem[32'h40008000] = 256'h0000;
         mem[32'h40008040] = 256'h1111;
         mem[32'h40018040] = 256'h2222;
         busy = 1'b0;
         cnt = 0;
         pmem_resp = 1'b0;
         pmem_rdata = '0;
      end

      // Memory model: responds 10 cycles after a command is seen; cancels on reset.
      always @(posedge clk) begin
         if (rst) begin
            busy <= 1'b0;
            cnt <= 0;
            pmem_resp <= 1'b0;
         end else if (pmem_resp) begin
            pmem_resp <= 1'b0;
            busy <= 1'b0;
         end else if (busy) begin
            if (cnt == 9) begin
               pmem_resp <= 1'b1;
               if (pmem_write) mem[pmem_address] = pmem_wdata;
               pmem_rdata <= mem.exists(pmem_address) ? mem[pmem_address] : '0;
            end
            cnt <= cnt + 1;
         end else if (pmem_read || pmem_write) begin
            busy <= 1'b1;
            cnt <= 1;
         end
      end
   end

   logic [255:0] m_i_rdata, m_d_rdata, m_wdata;
   logic         m_i_resp, m_d_resp, m_pr, m_pw;
   logic [31:0]  m_addr;

   always_comb begin
      m_i_rdata = sel ? g_u[1].i_rdata : g_u[0].i_rdata;
      m_d_rdata = sel ? g_u[1].d_rdata : g_u[0].d_rdata;
      m_wdata   = sel ? g_u[1].pmem_wdata : g_u[0].pmem_wdata;
      m_i_resp  = sel ? g_u[1].i_resp : g_u[0].i_resp;
      m_d_resp  = sel ? g_u[1].d_resp : g_u[0].d_resp;
      m_pr      = sel ? g_u[1].pmem_read : g_u[0].pmem_read;
      m_pw      = sel ? g_u[1].pmem_write : g_u[0].pmem_write;
      m_addr    = sel ? g_u[1].pmem_address : g_u[0].pmem_address;
   end

   // Scoreboard state
   logic [255:0] i_exp[$], d_exp[$], i_obs[$], d_obs[$];
   int           order[$];
   logic [31:0]  gnt_addr[$];
   logic         gnt_wr[$];
   logic [255:0] gnt_wd[$];
   int           gnt_cyc[$];
   int           dresp_cyc = 0;
   int           req_cyc_i = 0;
   logic         prev_active = 1'b0;
   int           n_cmp = 0;
   int           n_err = 0;

   // Monitor: records responses and grants of the selected instance.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_i_resp) begin
            i_obs.push_back(m_i_rdata);
            order.push_back(0);
            $display("txn u%0d I resp rdata=%h cyc=%0d", sel, m_i_rdata[31:0], cyc);
         end
         if (m_d_resp) begin
            if (!m_pw) d_obs.push_back(m_d_rdata);
            order.push_back(1);
            dresp_cyc = cyc;
            $display("txn u%0d D resp %s rdata=%h cyc=%0d", sel, m_pw ? "wr" : "rd",
                     m_d_rdata[31:0], cyc);
         end
      end
      if ((m_pr || m_pw) && !prev_active) begin
         gnt_addr.push_back(m_addr);
         gnt_wr.push_back(m_pw);
         gnt_wd.push_back(m_wdata);
         gnt_cyc.push_back(cyc);
      end
      prev_active = m_pr || m_pw;
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      i_exp.delete(); d_exp.delete(); i_obs.delete(); d_obs.delete(); order.delete();
      gnt_addr.delete(); gnt_wr.delete(); gnt_wd.delete(); gnt_cyc.delete();
   endtask

   task automatic req_i(input logic [31:0] a, input logic [255:0] e, output bit ok);
      @(negedge clk);
      i_address = a;
      i_read = 1'b1;
      i_exp.push_back(e);
      req_cyc_i = cyc;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (m_i_resp) begin ok = 1'b1; break; end
      end
      #1 i_read = 1'b0;
   endtask

   task automatic req_d(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                        input logic [255:0] e, output bit ok);
      @(negedge clk);
      d_address = a;
      d_wdata = wd;
      d_write = wr;
      d_read = !wr;
      if (!wr) d_exp.push_back(e);
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (m_d_resp) begin ok = 1'b1; break; end
      end
      #1 begin d_read = 1'b0; d_write = 1'b0; end
   endtask

   task automatic test_reset();
      logic [255:0] e;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         sel = 1'(u);
         #1;
         n_cmp++;
         if ({m_pr, m_pw, m_i_resp, m_d_resp} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl u%0d: got %b want 0000", u, {m_pr, m_pw, m_i_resp, m_d_resp});
         end
         n_cmp++;
         if (m_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_addr u%0d: got %h want 0", u, m_addr);
         end
         e = '0;
         n_cmp++;
         if (m_wdata !== e) begin
            n_err++; $display("FAIL reset_wdata u%0d: got %h want 0", u, m_wdata[31:0]);
         end
      end
      sel = 1'b1;
      rst = 1'b0;
   endtask

   task automatic test_single_i();
      bit ok;
      logic [255:0] e, o;
      sel = 1'b1;
      apply_reset();
      req_i(32'h40008000, 256'h0000, ok);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL single_i_timeout: got no i_resp want i_resp"); end
      n_cmp++;
      if (gnt_addr.size() != 1 || gnt_wr[0] !== 1'b0 || gnt_addr[0] !== 32'h40008000) begin
         n_err++; $display("FAIL single_i_grant: got %0d grants want 1 read of 40008000", gnt_addr.size());
      end else begin
         n_cmp++;
         if (gnt_cyc[0] - req_cyc_i != 1) begin
            n_err++; $display("FAIL single_i_latency: got %0d want 1", gnt_cyc[0] - req_cyc_i);
         end
      end
      n_cmp++;
      if (order.size() != 1 || order[0] != 0) begin
         n_err++; $display("FAIL single_i_resp_count: got %0d responses want exactly one I", order.size());
      end
      while (i_exp.size() > 0) begin
         e = i_exp.pop_front();
         n_cmp++;
         if (i_obs.size() == 0) begin
            n_err++; $display("FAIL single_i_data: got nothing want %h", e[31:0]);
         end else begin
            o = i_obs.pop_front();
            if (o !== e) begin n_err++; $display("FAIL single_i_data: got %h want %h", o[31:0], e[31:0]); end
         end
      end
   endtask

   task automatic test_write_read_d();
      bit ok;
      logic [255:0] e, o;
      sel = 1'b1;
      apply_reset();
      req_d(1'b1, 32'h40018040, 256'hf222, 256'h0, ok);
      n_cmp++;
      if (!ok || gnt_wr.size() != 1 || gnt_wr[0] !== 1'b1 || gnt_addr[0] !== 32'h40018040
          || gnt_wd[0] !== 256'hf222) begin
         n_err++; $display("FAIL d_write_cmd: got ok=%0d grants=%0d want one write of f222 to 40018040",
                           ok, gnt_wr.size());
      end
      req_d(1'b0, 32'h40018040, 256'h0, 256'hf222, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL d_read_timeout: got no d_resp want d_resp"); end
      while (d_exp.size() > 0) begin
         e = d_exp.pop_front();
         n_cmp++;
         if (d_obs.size() == 0) begin
            n_err++; $display("FAIL d_read_data: got nothing want %h", e[31:0]);
         end else begin
            o = d_obs.pop_front();
            if (o !== e) begin n_err++; $display("FAIL d_read_data: got %h want %h", o[31:0], e[31:0]); end
         end
      end
   endtask

   task automatic test_contention_rr();
      bit ok1, ok2;
      logic [255:0] e, o;
      sel = 1'b1;
      apply_reset();
      fork
         req_i(32'h40008000, 256'h0000, ok1);
         req_d(1'b0, 32'h40008040, 256'h0, 256'h1111, ok2);
      join
      n_cmp++;
      if (!ok1 || !ok2 || order.size() != 2 || order[0] != 1 || order[1] != 0) begin
         n_err++; $display("FAIL rr_order: got %0d responses (ok %0d/%0d) want D then I",
                           order.size(), ok1, ok2);
      end
      n_cmp++;
      if (gnt_cyc.size() != 2 || gnt_cyc[1] - dresp_cyc != 2) begin
         n_err++; $display("FAIL rr_idle_gap: got grants=%0d want I granted 2 cycles after d_resp",
                           gnt_cyc.size());
      end
      while (i_exp.size() > 0) begin
         e = i_exp.pop_front();
         n_cmp++;
         o = (i_obs.size() > 0) ? i_obs.pop_front() : 'x;
         if (o !== e) begin n_err++; $display("FAIL rr_i_data: got %h want %h", o[31:0], e[31:0]); end
      end
      while (d_exp.size() > 0) begin
         e = d_exp.pop_front();
         n_cmp++;
         o = (d_obs.size() > 0) ? d_obs.pop_front() : 'x;
         if (o !== e) begin n_err++; $display("FAIL rr_d_data: got %h want %h", o[31:0], e[31:0]); end
      end
   endtask

   task automatic test_back_to_back(input logic u, input int exp_order[4]);
      bit oki, okd0, okd1, okd2;
      logic [255:0] e, o;
      logic [255:0] mid;
      sel = u;
      apply_reset();
      mid = u ? 256'hf222 : 256'h2222;
      fork
         req_i(32'h40008040, 256'h1111, oki);
         begin
            req_d(1'b0, 32'h40008040, 256'h0, 256'h1111, okd0);
            req_d(1'b0, 32'h40018040, 256'h0, mid, okd1);
            req_d(1'b0, 32'h40008000, 256'h0, 256'h0000, okd2);
         end
      join
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (order.size() != 4 || order[k] != exp_order[k]) begin
            n_err++; $display("FAIL b2b_order u%0d slot %0d: got %0d of %0d want %0d (1=D 0=I)",
                              u, k, (order.size() > k) ? order[k] : -1, order.size(), exp_order[k]);
         end
      end
      while (i_exp.size() > 0) begin
         e = i_exp.pop_front();
         n_cmp++;
         o = (i_obs.size() > 0) ? i_obs.pop_front() : 'x;
         if (o !== e) begin n_err++; $display("FAIL b2b_i_data u%0d: got %h want %h", u, o[31:0], e[31:0]); end
      end
      while (d_exp.size() > 0) begin
         e = d_exp.pop_front();
         n_cmp++;
         o = (d_obs.size() > 0) ? d_obs.pop_front() : 'x;
         if (o !== e) begin n_err++; $display("FAIL b2b_d_data u%0d: got %h want %h", u, o[31:0], e[31:0]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [255:0] e, o;
      sel = 1'b1;
      apply_reset();
      @(negedge clk);
      d_address = 32'h40008000;
      d_wdata = 256'hdead;
      d_write = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (m_pw !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre: got pmem_write=%b want 1", m_pw); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (m_pw !== 1'b0 || m_pr !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_drop: got rd=%b wr=%b want 0 0", m_pr, m_pw);
      end
      d_write = 1'b0;
      rst = 1'b0;
      repeat (14) @(negedge clk);
      n_cmp++;
      if (order.size() != 0) begin
         n_err++; $display("FAIL rst_mid_noresp: got %0d responses want 0", order.size());
      end
      req_i(32'h40008000, 256'h0000, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rst_mid_after: got no i_resp want i_resp"); end
      while (i_exp.size() > 0) begin
         e = i_exp.pop_front();
         n_cmp++;
         o = (i_obs.size() > 0) ? i_obs.pop_front() : 'x;
         if (o !== e) begin n_err++; $display("FAIL rst_mid_data: got %h want %h", o[31:0], e[31:0]); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rr_ord[4];
      int fx_ord[4];
      rr_ord = '{1, 0, 1, 1};
      fx_ord = '{1, 1, 1, 0};
      test_reset();
      test_single_i();
      test_write_read_d();
      test_contention_rr();
      test_back_to_back(1'b1, rr_ord);
      test_reset_mid();
      test_back_to_back(1'b0, fx_ord);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
